// File: rtl/pipe_ctrl_pkg.sv
// Shared state encodings and PC-source codes for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_DRAIN  = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  localparam logic [1:0] PC_SRC_ZERO = 2'b00;
  localparam logic [1:0] PC_SRC_INC  = 2'b01;
  localparam logic [1:0] PC_SRC_BR   = 2'b10;

endpackage

// File: rtl/pipe_ctrl_hazard_unit.sv
// Load-use hazard detector: flags an ID instruction that reads the register a load in EXE is about to write.
import pipe_ctrl_pkg::*;

module hazard_unit #(
  parameter int RFW = 5
) (
  input  logic [RFW-1:0] id_rs1,
  input  logic [RFW-1:0] id_rs2,
  input  logic           id_use_rs1,
  input  logic           id_use_rs2,
  input  logic [RFW-1:0] ex_rd,
  input  logic           ex_is_load,
  output logic           load_use
);

  logic rs1_hit;
  logic rs2_hit;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing and hazard controller (start-up, load-use stall, branch flush, halt drain).
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
  parameter int RFW   = 5,
  parameter int IMW   = 4,
  parameter int DEPTH = 5,
  parameter int CW    = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           halt_req,
  input  logic [RFW-1:0] id_rs1,
  input  logic [RFW-1:0] id_rs2,
  input  logic           id_use_rs1,
  input  logic           id_use_rs2,
  input  logic [RFW-1:0] ex_rd,
  input  logic           ex_is_load,
  input  logic           ex_br_taken,
  output logic           pc_en,
  output logic [1:0]     pc_src,
  output logic           if_id_en,
  output logic           if_id_flush,
  output logic           id_exe_flush,
  output logic           running,
  output logic           halted,
  output logic [CW-1:0]  stall_cycles,
  output logic [CW-1:0]  flush_events
);

  localparam int DCW = $clog2(DEPTH + 1);

  // The drain length is DEPTH-2 plus the terminal zero cycle, so fewer than 3 stages makes no sense.
  if (DEPTH < 3 || IMW < 1) begin : g_param_check
    $error("pipe_ctrl: DEPTH must be >= 3 and IMW >= 1");
  end

  state_t         state;
  state_t         state_nxt;
  logic [DCW-1:0] drain_cnt;
  logic [DCW-1:0] drain_nxt;
  logic           load_use;

  hazard_unit #(.RFW(RFW)) u_hazard (
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2),
    .ex_rd     (ex_rd),
    .ex_is_load(ex_is_load),
    .load_use  (load_use)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  // In RUN the branch outranks load-use, which outranks halt: a taken branch squashes both.
  always_comb begin
    state_nxt    = state;
    drain_nxt    = drain_cnt;
    pc_en        = 1'b0;
    pc_src       = PC_SRC_ZERO;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_exe_flush = 1'b0;
    case (state)
      ST_IDLE: begin
        pc_en = 1'b1;
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (ex_br_taken) begin
          pc_en        = 1'b1;
          pc_src       = PC_SRC_BR;
          if_id_en     = 1'b1;
          if_id_flush  = 1'b1;
          id_exe_flush = 1'b1;
        end else if (load_use) begin
          id_exe_flush = 1'b1;
        end else if (halt_req) begin
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          drain_nxt   = DCW'(DEPTH - 2);
          state_nxt   = ST_DRAIN;
        end else begin
          pc_en    = 1'b1;
          pc_src   = PC_SRC_INC;
          if_id_en = 1'b1;
        end
      end
      ST_DRAIN: begin
        if_id_en     = 1'b1;
        if_id_flush  = 1'b1;
        id_exe_flush = 1'b1;
        if (drain_cnt == '0) state_nxt = ST_HALTED;
        else                 drain_nxt = drain_cnt - 1'b1;
      end
      ST_HALTED: begin
        pc_en = 1'b1;
        if (start) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign running = (state == ST_RUN);
  assign halted  = (state == ST_HALTED);

`ifdef PIPE_CTRL_PERF_EN
  logic [CW-1:0] stall_q;
  logic [CW-1:0] flush_q;
  logic          stall_hit;
  logic          flush_hit;
  logic          restart;

  assign stall_hit = running && !ex_br_taken && load_use;
  assign flush_hit = running && ex_br_taken;
  assign restart   = halted && start;

  // Counters saturate rather than wrap so a long run never reports a misleadingly small value.
  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_hit && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_hit && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl; counter expectations follow PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

  localparam int RFW = 5;
  localparam int CW  = 16;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Control bundle without pc_src: {pc_en, if_id_en, if_id_flush, id_exe_flush, running, halted}
  localparam logic [5:0] C_IDLE   = 6'b100000;
  localparam logic [5:0] C_RUN    = 6'b110010;
  localparam logic [5:0] C_STALL  = 6'b000110;
  localparam logic [5:0] C_BRANCH = 6'b111110;
  localparam logic [5:0] C_HALT   = 6'b011010;
  localparam logic [5:0] C_DRAIN  = 6'b011100;
  localparam logic [5:0] C_HALTED = 6'b100001;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           halt_req;
  logic [RFW-1:0] id_rs1;
  logic [RFW-1:0] id_rs2;
  logic           id_use_rs1;
  logic           id_use_rs2;
  logic [RFW-1:0] ex_rd;
  logic           ex_is_load;
  logic           ex_br_taken;
  logic           pc_en;
  logic [1:0]     pc_src;
  logic           if_id_en;
  logic           if_id_flush;
  logic           id_exe_flush;
  logic           running;
  logic           halted;
  logic [CW-1:0]  stall_cycles;
  logic [CW-1:0]  flush_events;
  logic [5:0]     ctrl;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  assign ctrl = {pc_en, if_id_en, if_id_flush, id_exe_flush, running, halted};

  always #5 clk = ~clk;

  pipe_ctrl #(.RFW(RFW), .IMW(4), .DEPTH(5), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .halt_req    (halt_req),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .ex_br_taken (ex_br_taken),
    .pc_en       (pc_en),
    .pc_src      (pc_src),
    .if_id_en    (if_id_en),
    .if_id_flush (if_id_flush),
    .id_exe_flush(id_exe_flush),
    .running     (running),
    .halted      (halted),
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    start = 1'b0; halt_req = 1'b0; id_rs1 = '0; id_rs2 = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_rd = '0; ex_is_load = 1'b0; ex_br_taken = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_inputs();
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_checks++; if (ctrl !== C_IDLE) begin n_fail++; $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrl, C_IDLE); end
    n_checks++; if (pc_src !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_pc_src: got %b expected 00", pc_src); end
    n_checks++; if (stall_cycles !== '0 || flush_events !== '0) begin n_fail++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, flush_events); end
    next_cycle();
  endtask

  task automatic test_start;
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    n_checks++; if (ctrl !== C_IDLE) begin n_fail++; $display("[TB] FAIL start_idle_ctrl: got %b expected %b", ctrl, C_IDLE); end
    n_checks++; if (pc_src !== 2'b00) begin n_fail++; $display("[TB] FAIL start_idle_pc_src: got %b expected 00", pc_src); end
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    n_checks++; if (ctrl !== C_RUN) begin n_fail++; $display("[TB] FAIL start_run_ctrl: got %b expected %b", ctrl, C_RUN); end
    n_checks++; if (pc_src !== 2'b01) begin n_fail++; $display("[TB] FAIL start_run_pc_src: got %b expected 01", pc_src); end
    next_cycle();
  endtask

  task automatic test_load_use;
    ex_is_load = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_use_rs2 = 1'b1;
    @(negedge clk);
    n_checks++; if (ctrl !== C_STALL) begin n_fail++; $display("[TB] FAIL load_use_rs2_ctrl: got %b expected %b", ctrl, C_STALL); end
    exp_stall++;
    next_cycle();
    clear_inputs();
    @(negedge clk);
    n_checks++; if (ctrl !== C_RUN) begin n_fail++; $display("[TB] FAIL load_use_release_ctrl: got %b expected %b", ctrl, C_RUN); end
    n_checks++; if (stall_cycles !== CW'(PERF ? exp_stall : 0)) begin n_fail++; $display("[TB] FAIL load_use_stall_count: got %0d expected %0d", stall_cycles, PERF ? exp_stall : 0); end
    next_cycle();
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    @(negedge clk);
    n_checks++; if (ctrl !== C_STALL) begin n_fail++; $display("[TB] FAIL load_use_rs1_ctrl: got %b expected %b", ctrl, C_STALL); end
    exp_stall++;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_no_stall;
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    @(negedge clk);
    n_checks++; if (ctrl !== C_RUN) begin n_fail++; $display("[TB] FAIL no_stall_rd0_ctrl: got %b expected %b", ctrl, C_RUN); end
    n_checks++; if (pc_src !== 2'b01) begin n_fail++; $display("[TB] FAIL no_stall_rd0_pc_src: got %b expected 01", pc_src); end
    next_cycle();
    ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
    @(negedge clk);
    n_checks++; if (ctrl !== C_RUN) begin n_fail++; $display("[TB] FAIL no_stall_unused_src_ctrl: got %b expected %b", ctrl, C_RUN); end
    next_cycle();
    ex_is_load = 1'b0; ex_rd = 5'd9;
    @(negedge clk);
    n_checks++; if (ctrl !== C_RUN) begin n_fail++; $display("[TB] FAIL no_stall_not_load_ctrl: got %b expected %b", ctrl, C_RUN); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_branch;
    ex_br_taken = 1'b1; halt_req = 1'b1;
    ex_is_load = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_use_rs1 = 1'b1;
    @(negedge clk);
    n_checks++; if (ctrl !== C_BRANCH) begin n_fail++; $display("[TB] FAIL branch_ctrl: got %b expected %b", ctrl, C_BRANCH); end
    n_checks++; if (pc_src !== 2'b10) begin n_fail++; $display("[TB] FAIL branch_pc_src: got %b expected 10", pc_src); end
    exp_flush++;
    next_cycle();
    clear_inputs();
    @(negedge clk);
    n_checks++; if (ctrl !== C_RUN) begin n_fail++; $display("[TB] FAIL branch_stays_run_ctrl: got %b expected %b", ctrl, C_RUN); end
    n_checks++; if (flush_events !== CW'(PERF ? exp_flush : 0)) begin n_fail++; $display("[TB] FAIL branch_flush_count: got %0d expected %0d", flush_events, PERF ? exp_flush : 0); end
    n_checks++; if (stall_cycles !== CW'(PERF ? exp_stall : 0)) begin n_fail++; $display("[TB] FAIL branch_stall_count: got %0d expected %0d", stall_cycles, PERF ? exp_stall : 0); end
    next_cycle();
  endtask

  task automatic test_halt_drain;
    halt_req = 1'b1;
    @(negedge clk);
    n_checks++; if (ctrl !== C_HALT) begin n_fail++; $display("[TB] FAIL halt_ctrl: got %b expected %b", ctrl, C_HALT); end
    next_cycle();
    halt_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ex_br_taken = (i == 1);
      ex_is_load = (i == 2); ex_rd = 5'd2; id_rs1 = 5'd2; id_use_rs1 = 1'b1;
      @(negedge clk);
      n_checks++; if (ctrl !== C_DRAIN) begin n_fail++; $display("[TB] FAIL drain_ctrl_%0d: got %b expected %b", i, ctrl, C_DRAIN); end
      next_cycle();
    end
    clear_inputs();
    @(negedge clk);
    n_checks++; if (ctrl !== C_HALTED) begin n_fail++; $display("[TB] FAIL halted_ctrl: got %b expected %b", ctrl, C_HALTED); end
    n_checks++; if (pc_src !== 2'b00) begin n_fail++; $display("[TB] FAIL halted_pc_src: got %b expected 00", pc_src); end
    n_checks++; if (flush_events !== CW'(PERF ? exp_flush : 0)) begin n_fail++; $display("[TB] FAIL drain_flush_count: got %0d expected %0d", flush_events, PERF ? exp_flush : 0); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (ctrl !== C_HALTED) begin n_fail++; $display("[TB] FAIL halted_hold_ctrl: got %b expected %b", ctrl, C_HALTED); end
    next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    @(negedge clk);
    n_checks++; if (ctrl !== C_RUN) begin n_fail++; $display("[TB] FAIL restart_ctrl: got %b expected %b", ctrl, C_RUN); end
    n_checks++; if (stall_cycles !== '0 || flush_events !== '0) begin n_fail++; $display("[TB] FAIL restart_counters: got %0d/%0d expected 0/0", stall_cycles, flush_events); end
    next_cycle();
  endtask

  task automatic test_reset_mid_drain;
    ex_is_load = 1'b1; ex_rd = 5'd6; id_rs2 = 5'd6; id_use_rs2 = 1'b1;
    exp_stall++;
    next_cycle();
    clear_inputs();
    @(negedge clk);
    n_checks++; if (stall_cycles !== CW'(PERF ? exp_stall : 0)) begin n_fail++; $display("[TB] FAIL pre_reset_stall_count: got %0d expected %0d", stall_cycles, PERF ? exp_stall : 0); end
    halt_req = 1'b1;
    next_cycle();
    halt_req = 1'b0;
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (ctrl !== C_DRAIN) begin n_fail++; $display("[TB] FAIL reset_drain2_ctrl: got %b expected %b", ctrl, C_DRAIN); end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (ctrl !== C_IDLE) begin n_fail++; $display("[TB] FAIL reset_mid_drain_ctrl: got %b expected %b", ctrl, C_IDLE); end
    n_checks++; if (stall_cycles !== '0 || flush_events !== '0) begin n_fail++; $display("[TB] FAIL reset_mid_drain_counters: got %0d/%0d expected 0/0", stall_cycles, flush_events); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (ctrl !== C_IDLE) begin n_fail++; $display("[TB] FAIL idle_hold_ctrl: got %b expected %b", ctrl, C_IDLE); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_load_use();
    test_no_stall();
    test_branch();
    test_halt_drain();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Sequencing and hazard controller for the 5-stage RISC pipeline. Generates the PC update command and the IF/ID and ID/EXE buffer enable and flush controls. It handles:
- start-up, with PC forced to 0;
- one-cycle load-use stalls;
- two-bubble flushes on taken branches;
- orderly drain to a halted state on a HALT instruction.

It sits beside the PC, IF_ID and ID_EXE instances in CORE and owns no datapath state.

## Interface
Parameters:
- RFW, 5, register-address width
- IMW, 4, instruction-memory address width (PC width)
- DEPTH, 5, pipeline stage count; sets the drain length
- CW, 16, performance-counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin execution from PC 0 (level sampled in IDLE/HALTED)
- halt_req  in  1  instruction in ID is HALT
- id_rs1, id_rs2  in  RFW  source registers of instruction in ID
- id_use_rs1, id_use_rs2  in  1  corresponding source is actually read
- ex_rd  in  RFW  destination of instruction in EXE
- ex_is_load  in  1  instruction in EXE is a load
- ex_br_taken  in  1  branch in EXE resolved taken
- pc_en  out  1  PC register write enable
- pc_src  out  2  PC source: 00 zero, 01 PC+1, 10 branch target
- if_id_en  out  1  IF/ID buffer load enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_exe_flush  out  1  ID/EXE loads a bubble
- running  out  1  state is RUN
- halted  out  1  state is HALTED
- stall_cycles, flush_events  out  CW  performance counters (see Configuration)

## Operation
States are IDLE, RUN, DRAIN and HALTED. State and counters are registered; control outputs are combinational from state and inputs.

Per-state behaviour:
- **IDLE:** pc_en=1, pc_src=00, all other controls 0.
  - start=1 → RUN.
- **RUN:** evaluated in priority order; the first matching case applies.
  1. **Branch** (ex_br_taken=1): pc_en=1, pc_src=10, if_id_en=1, if_id_flush=1, id_exe_flush=1. Stay in RUN. halt_req and load-use are ignored this cycle.
  2. **Load-use** (ex_is_load and ex_rd≠0 and ((id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd))): pc_en=0, if_id_en=0, id_exe_flush=1. Stay in RUN.
  3. **Halt** (halt_req=1): pc_en=0, if_id_en=1, if_id_flush=1. Load drain_cnt=DEPTH-2 and go to DRAIN.
  4. **Normal:** pc_en=1, pc_src=01, if_id_en=1, flushes 0.
  - start is ignored in RUN.
- **DRAIN:** pc_en=0, if_id_en=1, if_id_flush=1, id_exe_flush=1. drain_cnt decrements each cycle; at drain_cnt==0 → HALTED. Branch and load-use inputs are ignored.
- **HALTED:** halted=1, pc_en=1, pc_src=00.
  - start=1 → RUN; this restarts at PC 0.

Reset: rst_n=0 at an edge forces IDLE, drain_cnt=0 and counters=0, regardless of state, including mid-DRAIN or mid-stall.

Outputs while rst_n=0 and in IDLE: pc_en=1, pc_src=00, if_id_en=0, if_id_flush=0, id_exe_flush=0, running=0, halted=0.

## Timing
- start is sampled at edge k in IDLE: PC=0 after edge k, state=RUN; instruction 0 is in IF during cycle k+1.
- Load-use stall lasts exactly 1 cycle. The following cycle the hazard has cleared because a bubble now occupies EXE.
- A taken branch costs exactly 2 bubbles; the target is fetched the cycle after resolution.
- halt_req seen at edge h: halted=1 from edge h+DEPTH-1 onward (4 cycles for DEPTH=5). All older instructions retire; no younger instruction executes.
- A branch and halt_req in the same cycle are resolved as branch; the HALT is flushed.

## Configuration
- **PIPE_CTRL_PERF_EN defined:**
  - stall_cycles increments on each load-use stall cycle.
  - flush_events increments on each taken-branch flush.
  - Both saturate at 2^CW-1, clear on reset, and clear on start from HALTED.
- **PIPE_CTRL_PERF_EN undefined:** counters are not built; both ports are tied to 0.

## Structure
- Package pipe_ctrl_pkg holds:
  - state encodings ST_IDLE, ST_RUN, ST_DRAIN, ST_HALTED (2-bit);
  - PC_SRC_ZERO, PC_SRC_INC, PC_SRC_BR.
- Sub-module hazard_unit: combinational load-use compare producing a single load_use bit, parameterised by RFW.

## Test plan
- Reset then start=1 for one cycle → pc_src=00 in the IDLE cycle, running=1 next cycle, pc_en=1/pc_src=01 afterwards; halted=0.
- ex_is_load=1, ex_rd=3, id_rs2=3, id_use_rs2=1 for one cycle → pc_en=0, if_id_en=0, id_exe_flush=1 for exactly 1 cycle; stall_cycles=1 with PIPE_CTRL_PERF_EN.
- ex_rd=0 with matching rs1 and ex_is_load=1 → no stall.
- ex_br_taken=1 together with halt_req=1 and a load-use match → pc_src=10, both flushes=1, state stays RUN; flush_events=1.
- halt_req=1 in RUN → DRAIN with bubbles for 4 cycles, then halted=1, pc_en=1/pc_src=00. start=1 → running=1 next cycle.
- rst_n=0 during the second DRAIN cycle → next cycle IDLE; halted=0; counters=0.
